// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and
// stop bits around an external bit serializer and drives the TX line.
module uart_tx_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             DATA_VALID,
   input  logic [WIDTH-1:0] P_DATA,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   input  logic             serial_data,
   input  logic             serial_done,
   output logic             serial_en,
   output logic             TX_OUT,
   output logic             busy,
   output logic             frame_done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t state, next_state;
   logic   parity_q;
   logic   par_en_q;

   // Frame configuration is captured only on accept, so mid-frame changes
   // on PAR_EN/PAR_TYP and illegal strobes while busy are ignored.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         // NOTE: non-blocking assignments keep every register update in this
         // block using pre-edge values, independent of statement order.
         state    <= IDLE;
         parity_q <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && DATA_VALID) begin
            par_en_q <= PAR_EN;
            parity_q <= (^P_DATA) ^ PAR_TYP;
         end
      end
   end

   always_comb begin
      // NOTE: assigning a default first guarantees no latch is inferred for
      // any path through the case statement below.
      next_state = state;
      case (state)
         IDLE:    if (DATA_VALID) next_state = START;
         START:   next_state = DATA;
         DATA:    if (serial_done) next_state = par_en_q ? PARITY : STOP;
         PARITY:  next_state = STOP;
         STOP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      TX_OUT     = 1'b1;
      busy       = 1'b0;
      serial_en  = 1'b0;
      frame_done = 1'b0;
      case (state)
         START: begin
            TX_OUT    = 1'b0;
            busy      = 1'b1;
            serial_en = 1'b1;
         end
         DATA: begin
            TX_OUT    = serial_data;
            busy      = 1'b1;
            serial_en = 1'b1;
         end
         // Dropping serial_en here returns the serializer counter to zero.
         PARITY: begin
            TX_OUT = parity_q;
            busy   = 1'b1;
         end
         STOP: begin
            busy       = 1'b1;
            frame_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural 3-bit-counter serializer
// alongside it; expected line patterns are hand-derived constants.
module tb_uart_tx_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic       DATA_VALID;
   logic [7:0] P_DATA;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       serial_data;
   logic       serial_done;
   logic       serial_en;
   logic       TX_OUT;
   logic       busy;
   logic       frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_ctrl #(.WIDTH(8)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .DATA_VALID  (DATA_VALID),
      .P_DATA      (P_DATA),
      .PAR_EN      (PAR_EN),
      .PAR_TYP     (PAR_TYP),
      .serial_data (serial_data),
      .serial_done (serial_done),
      .serial_en   (serial_en),
      .TX_OUT      (TX_OUT),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 CLK = ~CLK;

   // Serializer peer: loads when idle, presents one bit per enabled cycle.
   logic [7:0] ser_sr;
   logic [2:0] ser_cnt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ser_sr      <= 8'h00;
         ser_cnt     <= 3'd0;
         serial_data <= 1'b0;
         serial_done <= 1'b0;
      end else begin
         serial_done <= serial_en && (ser_cnt == 3'd7);
         if (serial_en) begin
            serial_data <= ser_sr[ser_cnt];
            ser_cnt     <= ser_cnt + 3'd1;
         end else begin
            ser_cnt <= 3'd0;
            if (DATA_VALID && ser_cnt == 3'd0) ser_sr <= P_DATA;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // exp[i-1] is the required TX_OUT in frame cycle i (cycle 1 = START).
   task automatic send(input string name, input logic [7:0] d, input logic pen,
                       input logic ptyp, input logic [0:10] exp, input int len,
                       input int toggle_at);
      @(negedge CLK);
      check({name, " idle tx"},   32'(TX_OUT), 32'd1);
      check({name, " idle busy"}, 32'(busy),   32'd0);
      P_DATA     = d;
      PAR_EN     = pen;
      PAR_TYP    = ptyp;
      DATA_VALID = 1'b1;
      @(posedge CLK);
      #1 DATA_VALID = 1'b0;
      for (int i = 1; i <= len; i++) begin
         @(negedge CLK);
         check($sformatf("%s tx c%0d", name, i),   32'(TX_OUT),     32'(exp[i-1]));
         check($sformatf("%s busy c%0d", name, i), 32'(busy),       32'd1);
         check($sformatf("%s sen c%0d", name, i),  32'(serial_en),  32'(i <= 9));
         check($sformatf("%s fd c%0d", name, i),   32'(frame_done), 32'(i == len));
         if (i == toggle_at) begin
            PAR_EN     = ~PAR_EN;
            PAR_TYP    = ~PAR_TYP;
            DATA_VALID = 1'b1;
         end else begin
            DATA_VALID = 1'b0;
         end
      end
   endtask

   initial begin
      RST        = 1'b0;
      DATA_VALID = 1'b0;
      P_DATA     = 8'h00;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      #12;
      check("rst tx",   32'(TX_OUT),     32'd1);
      check("rst busy", 32'(busy),       32'd0);
      check("rst sen",  32'(serial_en),  32'd0);
      check("rst fd",   32'(frame_done), 32'd0);
      @(negedge CLK);
      RST = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         check($sformatf("idle tx %0d", i),   32'(TX_OUT),    32'd1);
         check($sformatf("idle busy %0d", i), 32'(busy),      32'd0);
         check($sformatf("idle sen %0d", i),  32'(serial_en), 32'd0);
      end

      send("a5_np", 8'hA5, 1'b0, 1'b0, 11'b01010010111, 10, 0);
      send("a5_ev", 8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, 0);
      send("a5_od", 8'hA5, 1'b1, 1'b1, 11'b01010010111, 11, 0);

      // Back-to-back: second accept lands in the first idle cycle.
      send("01_od", 8'h01, 1'b1, 1'b1, 11'b01000000001, 11, 0);
      send("ff_od", 8'hFF, 1'b1, 1'b1, 11'b01111111111, 11, 0);

      // Abort during DATA bit 3 (frame cycle 5).
      @(negedge CLK);
      P_DATA     = 8'hA5;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      DATA_VALID = 1'b1;
      @(posedge CLK);
      #1 DATA_VALID = 1'b0;
      for (int i = 1; i <= 5; i++) @(negedge CLK);
      check("abort pre tx",   32'(TX_OUT), 32'd0);
      check("abort pre busy", 32'(busy),   32'd1);
      #2 RST = 1'b0;
      #1;
      check("abort tx",   32'(TX_OUT),    32'd1);
      check("abort busy", 32'(busy),      32'd0);
      check("abort sen",  32'(serial_en), 32'd0);
      @(negedge CLK);
      check("abort held busy", 32'(busy), 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      check("post rst tx",   32'(TX_OUT), 32'd1);
      check("post rst busy", 32'(busy),   32'd0);

      send("3c_np", 8'h3C, 1'b0, 1'b0, 11'b00011110011, 10, 0);

      // PAR_EN/PAR_TYP flipped and an illegal strobe during DATA bit 3.
      send("a5_tog", 8'hA5, 1'b1, 1'b1, 11'b01010010111, 11, 5);

      @(negedge CLK);
      check("end tx",   32'(TX_OUT), 32'd1);
      check("end busy", 32'(busy),   32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
